muldiv_seq: RTL and testbench

Multi-cycle sequencer that implements RV32M MUL, DIVU and REMU by time-sharing the existing single-cycle ALU. The ALU itself has no multiplier or divider.
- On a request from the decode/stall logic, the sequencer takes ownership of the ALU input mux (alu_own) for a fixed number of cycles.
- It iterates shift-add or restoring division.
- It returns the 32-bit result with a one-cycle done pulse while the core is stalled on busy.

---
 rtl/core_ctrl_pkg.sv | 10 +
 rtl/muldiv_pkg.sv | 22 ++
 rtl/muldiv_seq_if.sv | 29 ++
 rtl/muldiv_seq.sv | 175 +++++++++++++++++
 tb/tb_muldiv_seq.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/core_ctrl_pkg.sv
// Shared core control encodings: ALU operation select codes used by the ALU,
// the decode stage and any unit that borrows the ALU.
package core_ctrl_pkg;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_SLTU = 4'd3;
    localparam logic [3:0] ALU_A    = 4'd9;

endpackage

// File: rtl/muldiv_pkg.sv
// Types and sizing shared by the multi-cycle MUL/DIVU/REMU sequencer.
package muldiv_pkg;

    localparam int MD_WIDTH = 32;
    localparam int MD_CNT_W = $clog2(MD_WIDTH);

    typedef enum logic [1:0] {
        OP_MUL  = 2'd0,
        OP_DIVU = 2'd1,
        OP_REMU = 2'd2,
        OP_RSVD = 2'd3
    } op_sel_e;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_MUL_RUN = 3'd1,
        ST_DIV_CMP = 3'd2,
        ST_DIV_SUB = 3'd3,
        ST_FINISH  = 3'd4
    } state_e;

endpackage

// File: rtl/muldiv_seq_if.sv
// Request/response and borrowed-ALU signals between the core and muldiv_seq.
interface muldiv_seq_if #(
    parameter int WIDTH   = 32,
    parameter int ALU_SEL = 4
);
    logic               op_start;
    logic [1:0]         op_sel;
    logic [WIDTH-1:0]   op_a;
    logic [WIDTH-1:0]   op_b;
    logic               kill;
    logic               busy;
    logic               done;
    logic [WIDTH-1:0]   result;
    logic               alu_own;
    logic [WIDTH-1:0]   alu_a;
    logic [WIDTH-1:0]   alu_b;
    logic [ALU_SEL-1:0] alu_sel;
    logic [WIDTH-1:0]   alu_out;

    modport master (
        output op_start, op_sel, op_a, op_b, kill, alu_out,
        input  busy, done, result, alu_own, alu_a, alu_b, alu_sel
    );

    modport slave (
        input  op_start, op_sel, op_a, op_b, kill, alu_out,
        output busy, done, result, alu_own, alu_a, alu_b, alu_sel
    );
endinterface

// File: rtl/muldiv_seq.sv
// RV32M MUL / DIVU / REMU sequencer that time-shares the core ALU:
// shift-add multiply and restoring divide, one ALU operation per cycle.
module muldiv_seq
    import muldiv_pkg::*;
    import core_ctrl_pkg::*;
#(
    parameter int WIDTH   = MD_WIDTH,
    parameter int ALU_SEL = 4
) (
    input  logic        clk,
    input  logic        rstn,
    muldiv_seq_if.slave bus
);

    localparam int               CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [WIDTH-1:0] ZERO_W   = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONES_W   = {WIDTH{1'b1}};

    state_e             r_state;
    state_e             w_step;
    state_e             w_next;
    op_sel_e            r_op;
    logic [WIDTH-1:0]   r_acc;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_result;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_sub;
    logic               r_done;

    logic               w_accept;
    logic               w_start_div;
    logic               w_abort;
    logic               w_div0;
    logic               w_sub;
    logic [WIDTH-1:0]   w_rem_sh;
    logic [WIDTH-1:0]   w_fin_result;
    logic               w_own;
    logic [WIDTH-1:0]   w_alu_a;
    logic [WIDTH-1:0]   w_alu_b;
    logic [ALU_SEL-1:0] w_alu_sel;

    assign w_accept    = (r_state == ST_IDLE) && bus.op_start && !bus.kill;
    assign w_start_div = (bus.op_sel == OP_DIVU) || (bus.op_sel == OP_REMU);
    assign w_abort     = (r_state != ST_IDLE) && bus.kill;
    assign w_div0      = (r_b == ZERO_W);

    // r_acc doubles as the partial remainder; r_a shifts the dividend out of
    // its MSB while quotient bits shift in at the LSB.
    assign w_rem_sh = {r_acc[WIDTH-2:0], r_a[WIDTH-1]};
    assign w_sub    = r_acc[WIDTH-1] | ~bus.alu_out[0];

    // Final value for the current operation, including divide-by-zero rules.
    always_comb begin
        w_fin_result = r_acc;
        case (r_op)
            OP_DIVU: w_fin_result = w_div0 ? ONES_W : r_a;
            OP_REMU: w_fin_result = w_div0 ? r_a : r_acc;
            default: w_fin_result = r_acc;
        endcase
    end

    // Next-state and ALU drive decode.
    always_comb begin
        w_step    = r_state;
        w_own     = 1'b0;
        w_alu_a   = ZERO_W;
        w_alu_b   = ZERO_W;
        w_alu_sel = ALU_SEL'(ALU_ADD);
        case (r_state)
            ST_IDLE: begin
                if (!w_accept) begin
                    w_step = ST_IDLE;
                end else if (!w_start_div) begin
                    w_step = ST_MUL_RUN;
                end else if (bus.op_b == ZERO_W) begin
                    w_step = ST_FINISH;
                end else begin
                    w_step = ST_DIV_CMP;
                end
            end
            ST_MUL_RUN: begin
                w_own   = 1'b1;
                w_alu_a = r_acc;
                w_alu_b = r_b[0] ? r_a : ZERO_W;
                w_step  = (r_cnt == CNT_ZERO) ? ST_FINISH : ST_MUL_RUN;
            end
            ST_DIV_CMP: begin
                w_own     = 1'b1;
                w_alu_a   = w_rem_sh;
                w_alu_b   = r_b;
                w_alu_sel = ALU_SEL'(ALU_SLTU);
                w_step    = ST_DIV_SUB;
            end
            ST_DIV_SUB: begin
                w_own     = 1'b1;
                w_alu_a   = w_rem_sh;
                w_alu_b   = r_b;
                w_alu_sel = r_sub ? ALU_SEL'(ALU_SUB) : ALU_SEL'(ALU_A);
                w_step    = (r_cnt == CNT_ZERO) ? ST_FINISH : ST_DIV_CMP;
            end
            ST_FINISH: w_step = ST_IDLE;
            default:   w_step = ST_IDLE;
        endcase
        w_next = w_abort ? ST_IDLE : w_step;
    end

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Operand, accumulator, counter and result registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_op     <= OP_MUL;
            r_acc    <= ZERO_W;
            r_a      <= ZERO_W;
            r_b      <= ZERO_W;
            r_result <= ZERO_W;
            r_cnt    <= CNT_ZERO;
            r_sub    <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_op  <= w_start_div ? op_sel_e'(bus.op_sel) : OP_MUL;
                        r_a   <= bus.op_a;
                        r_b   <= bus.op_b;
                        r_acc <= ZERO_W;
                        r_cnt <= CNT_LAST;
                        r_sub <= 1'b0;
                    end
                end
                ST_MUL_RUN: begin
                    r_acc <= bus.alu_out;
                    r_a   <= {r_a[WIDTH-2:0], 1'b0};
                    r_b   <= {1'b0, r_b[WIDTH-1:1]};
                    r_cnt <= r_cnt - CNT_ONE;
                end
                ST_DIV_CMP: r_sub <= w_sub;
                ST_DIV_SUB: begin
                    r_acc <= bus.alu_out;
                    r_a   <= {r_a[WIDTH-2:0], r_sub};
                    r_cnt <= r_cnt - CNT_ONE;
                end
                ST_FINISH: begin
                    if (!bus.kill) begin
                        r_done   <= 1'b1;
                        r_result <= w_fin_result;
                    end
                end
                default: r_done <= 1'b0;
            endcase
        end
    end

    assign bus.busy    = (r_state != ST_IDLE);
    assign bus.done    = r_done;
    assign bus.result  = r_result;
    assign bus.alu_own = w_own;
    assign bus.alu_a   = w_alu_a;
    assign bus.alu_b   = w_alu_b;
    assign bus.alu_sel = w_alu_sel;

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for muldiv_seq with a behavioural ALU and ownership mux.
module tb_muldiv_seq;
    import core_ctrl_pkg::*;

    logic clk;
    logic rstn;
    int   n_chk;
    int   n_err;

    muldiv_seq_if #(.WIDTH(32), .ALU_SEL(4)) bus ();

    muldiv_seq #(.WIDTH(32), .ALU_SEL(4)) u_dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    // Core-side ALU drive, deliberately non-zero so a missing alu_own shows up.
    logic [31:0] core_a;
    logic [31:0] core_b;
    logic [3:0]  core_sel;
    logic [31:0] mux_a;
    logic [31:0] mux_b;
    logic [3:0]  mux_sel;
    logic [31:0] alu_res;

    assign core_a   = 32'h1234_5678;
    assign core_b   = 32'h0F0F_0F0F;
    assign core_sel = ALU_ADD;
    assign mux_a    = bus.alu_own ? bus.alu_a   : core_a;
    assign mux_b    = bus.alu_own ? bus.alu_b   : core_b;
    assign mux_sel  = bus.alu_own ? bus.alu_sel : core_sel;

    always_comb begin
        case (mux_sel)
            ALU_ADD:  alu_res = mux_a + mux_b;
            ALU_SUB:  alu_res = mux_a - mux_b;
            ALU_SLTU: alu_res = {31'd0, (mux_a < mux_b)};
            ALU_A:    alu_res = mux_a;
            default:  alu_res = mux_a ^ mux_b;
        endcase
    end
    assign bus.alu_out = alu_res;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic start_op(input logic [1:0] sel, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        bus.op_start = 1'b1;
        bus.op_sel   = sel;
        bus.op_a     = a;
        bus.op_b     = b;
        @(posedge clk);
        #1;
        bus.op_start = 1'b0;
    endtask

    // Start an operation and check result, done latency, alu_own cycles and pulse width.
    task automatic run_op(input string tag, input logic [1:0] sel, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_res,
                          input int exp_lat, input int exp_own);
        int lat;
        int own;
        lat = -1;
        own = 0;
        start_op(sel, a, b);
        if (bus.alu_own) own++;
        for (int k = 1; k <= 200; k++) begin
            @(posedge clk);
            #1;
            if (bus.done) begin
                lat = k;
                break;
            end
            if (bus.alu_own) own++;
        end
        check_val({tag, "_lat"}, lat, exp_lat);
        check_val({tag, "_res"}, bus.result, exp_res);
        check_val({tag, "_own"}, own, exp_own);
        @(posedge clk);
        #1;
        check_val({tag, "_pulse"}, {31'd0, bus.done}, 32'd0);
    endtask

    initial begin
        int seen;
        int gap;
        n_chk        = 0;
        n_err        = 0;
        rstn         = 1'b0;
        bus.op_start = 1'b0;
        bus.op_sel   = 2'd0;
        bus.op_a     = 32'd0;
        bus.op_b     = 32'd0;
        bus.kill     = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_busy",   {31'd0, bus.busy},    32'd0);
        check_val("rst_done",   {31'd0, bus.done},    32'd0);
        check_val("rst_own",    {31'd0, bus.alu_own}, 32'd0);
        check_val("rst_result", bus.result,           32'd0);
        check_val("rst_alu_a",  bus.alu_a,            32'd0);
        check_val("rst_alu_b",  bus.alu_b,            32'd0);
        check_val("rst_alu_sel", {28'd0, bus.alu_sel}, {28'd0, ALU_ADD});
        @(negedge clk);
        rstn = 1'b1;

        run_op("mul_7x6",    2'd0, 32'd7,          32'd6,          32'h0000_002A, 33, 32);
        run_op("mul_ffxff",  2'd0, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'h0000_0001, 33, 32);
        run_op("mul_msbx2",  2'd0, 32'h8000_0000,  32'd2,          32'h0000_0000, 33, 32);
        run_op("mul_rsvd",   2'd3, 32'd12,         32'd5,          32'd60,        33, 32);
        run_op("divu_100_7", 2'd1, 32'd100,        32'd7,          32'd14,        65, 64);
        run_op("remu_100_7", 2'd2, 32'd100,        32'd7,          32'd2,         65, 64);
        run_op("divu_big",   2'd1, 32'hFFFF_FFFF,  32'h8000_0001,  32'd1,         65, 64);
        run_op("remu_big",   2'd2, 32'hFFFF_FFFF,  32'h8000_0001,  32'h7FFF_FFFE, 65, 64);
        run_op("divu_small", 2'd1, 32'd7,          32'd9,          32'd0,         65, 64);
        run_op("remu_small", 2'd2, 32'd7,          32'd9,          32'd7,         65, 64);
        run_op("divu_by0",   2'd1, 32'd5,          32'd0,          32'hFFFF_FFFF, 1,  0);
        run_op("remu_by0",   2'd2, 32'd5,          32'd0,          32'd5,         1,  0);

        // Kill during DIV_CMP: no done, result keeps 5 from the previous op.
        start_op(2'd1, 32'd100, 32'd7);
        repeat (10) @(posedge clk);
        #1;
        check_val("kill_in_cmp", {28'd0, bus.alu_sel}, {28'd0, ALU_SLTU});
        bus.kill = 1'b1;
        @(posedge clk);
        #1;
        bus.kill = 1'b0;
        check_val("kill_busy", {31'd0, bus.busy},    32'd0);
        check_val("kill_own",  {31'd0, bus.alu_own}, 32'd0);
        seen = 0;
        for (int k = 0; k < 70; k++) begin
            @(posedge clk);
            #1;
            if (bus.done) seen++;
        end
        check_val("kill_no_done", seen, 32'd0);
        check_val("kill_result",  bus.result, 32'd5);
        run_op("mul_3x3", 2'd0, 32'd3, 32'd3, 32'd9, 33, 32);

        // Kill in IDLE blocks a simultaneous start.
        @(negedge clk);
        bus.op_start = 1'b1;
        bus.kill     = 1'b1;
        bus.op_sel   = 2'd0;
        @(posedge clk);
        #1;
        bus.op_start = 1'b0;
        bus.kill     = 1'b0;
        check_val("idle_kill_busy", {31'd0, bus.busy}, 32'd0);

        // Kill in FINISH (divide by zero): no done, result stays 9.
        start_op(2'd1, 32'd5, 32'd0);
        bus.kill = 1'b1;
        @(posedge clk);
        #1;
        bus.kill = 1'b0;
        check_val("fin_kill_done",   {31'd0, bus.done}, 32'd0);
        check_val("fin_kill_result", bus.result,        32'd9);

        // op_start held high: one operation per IDLE visit, 34 cycles apart.
        @(negedge clk);
        bus.op_start = 1'b1;
        bus.op_sel   = 2'd0;
        bus.op_a     = 32'd2;
        bus.op_b     = 32'd3;
        seen = 0;
        for (int k = 0; k < 100; k++) begin
            @(posedge clk);
            #1;
            if (bus.done) begin
                seen = 1;
                break;
            end
        end
        check_val("hold_first_done", seen, 32'd1);
        check_val("hold_result",     bus.result, 32'd6);
        gap = -1;
        for (int k = 1; k <= 100; k++) begin
            @(posedge clk);
            #1;
            if (k == 1) check_val("hold_reaccept", {31'd0, bus.busy}, 32'd1);
            if (bus.done) begin
                gap = k;
                break;
            end
        end
        bus.op_start = 1'b0;
        check_val("hold_gap", gap, 32'd34);
        @(posedge clk);
        #1;
        check_val("hold_stop", {31'd0, bus.busy}, 32'd0);

        // Asynchronous reset mid-MUL.
        start_op(2'd0, 32'd7, 32'd6);
        repeat (10) @(posedge clk);
        @(negedge clk);
        rstn = 1'b0;
        #1;
        check_val("arst_busy",   {31'd0, bus.busy},    32'd0);
        check_val("arst_own",    {31'd0, bus.alu_own}, 32'd0);
        check_val("arst_done",   {31'd0, bus.done},    32'd0);
        check_val("arst_result", bus.result,           32'd0);
        check_val("arst_alu_a",  bus.alu_a,            32'd0);
        check_val("arst_alu_b",  bus.alu_b,            32'd0);
        @(negedge clk);
        rstn = 1'b1;
        seen = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            if (bus.done || bus.busy) seen++;
        end
        check_val("arst_idle", seen, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
